seg_scan_n: RTL
===============

SEG_SCAN_N -- requirements
Module: seg_scan_n

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 Parameter SCAN_DIV, default 131072: clk cycles per digit slot, at least 2^BRIGHT_BITS.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period.
REQ-004 Parameter BRIGHT_BITS, default 4: brightness resolution in bits.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 hexs  in  4*N_DIGITS  digit values; digit i occupies [4i+3:4i]; digit 0 is rightmost.
REQ-008 les  in  N_DIGITS  per-digit enable; 1 = show.
REQ-009 points  in  N_DIGITS  per-digit decimal point; 1 = lit.
REQ-010 blink  in  N_DIGITS  per-digit blink enable; 1 = blink.
REQ-011 lzb  in  1  leading-zero blanking enable.
REQ-012 bright  in  BRIGHT_BITS  duty level; 0 = dark, all-ones = full on.
REQ-013 AN  out  N_DIGITS  digit select, active-low, at most one bit low.
REQ-014 SEGMENT  out  8  active-low segments; [0..6] = a..g, [7] = point.
REQ-015 frame_tick  out  1  one-cycle pulse when digit 0 slot begins.

Function
REQ-016 Slot counter counts 0..SCAN_DIV-1 and wraps; on wrap, digit index increments, N_DIGITS-1 -> 0.
REQ-017 hexs, les, points, blink, lzb and bright are captured into shadow registers in the cycle index enters 0 (frame start); the whole frame displays the shadow copy, so there is no tearing.
REQ-018 frame_tick is asserted in the same cycle as the shadow capture.
REQ-019 Blink counter counts frames 0..BLINK_FRAMES-1; on wrap, blink phase toggles; phase 1 = on after reset.
REQ-020 The digit is dark when any of the following holds: les bit = 0; blink bit = 1 while phase = 0; LZB-blanked; PWM off.
REQ-021 LZB: with lzb = 1, digits from N_DIGITS-1 downward are blanked while their value is 0, up to the first nonzero digit; digit 0 is never blanked; the blank state is computed per frame from the shadow copy.
REQ-022 PWM: pwm = slot counter [BRIGHT_BITS-1:0]; lit when pwm < bright, or when bright is all ones.
REQ-023 Dark digit: AN = all ones and SEGMENT = 8'hFF, including the point.
REQ-024 Lit digit: AN bit [index] = 0 with all others 1; SEGMENT = decoded hex with point = ~points[index].
REQ-025 Decode values 0..F to the standard hex glyphs (A, b, C, d, E, F).
REQ-026 AN and SEGMENT are registered, one clk after index and counter state.
REQ-027 Input changes mid-frame take effect only at the next frame start.

Reset
REQ-028 While RST = 0:
- AN = all ones, SEGMENT = 8'hFF, frame_tick = 0
- index = 0, slot counter = 0, blink counter = 0, blink phase = 1
- shadow registers = 0
REQ-029 Release of RST is synchronised to clk with two flops before counters run; the first frame_tick occurs on the first active cycle after release.

Structure
REQ-030 Package seg_scan_pkg holds the glyph table (16 x 7-bit constants), SEG_OFF = 8'hFF and the index width function clog2(N_DIGITS).
REQ-031 Sub-module seg7_decode is purely combinational: 4-bit hex in, 7-bit active-low segments out.

Verification
Bench configuration: N_DIGITS=4, SCAN_DIV=16, BRIGHT_BITS=4, BLINK_FRAMES=2 unless stated.
REQ-032 Scan: hexs=16'h1234, les=4'hF, bright=4'hF -> AN cycles 1110, 1101, 1011, 0111, 16 clks each; SEGMENT decodes 4, 3, 2, 1; frame_tick every 64 clks.
REQ-033 LZB: hexs=16'h0050, lzb=1 -> digits 3 and 2 dark; digits 1 and 0 show 5 and 0. With hexs=16'h0000 -> only digit 0 lit, showing 0.
REQ-034 Brightness: bright=4'h4 -> exactly 4 of 16 clks per slot have AN active; bright=0 -> AN stays all ones.
REQ-035 Blink: blink=4'b0001 -> digit 0 dark for 2 frames, then lit for 2 frames, repeating; other digits steady.
REQ-036 Tearing and reset: change hexs mid-frame -> old value is held until next frame_tick. Assert RST=0 mid-slot -> AN=4'hF and SEGMENT=8'hFF immediately; after release, the first lit digit is index 0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - glyph table and shared constants for the multiplexed 7-segment scanner
package seg_scan_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low a..g in bits [0..6], indexed by hex value 0..F
    localparam logic [6:0] GLYPHS [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex to active-low 7-segment decoder
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPHS[hex_i];

endmodule

// File: rtl/seg_scan_n.sv
// rtl/seg_scan_n.sv - N-digit multiplexed 7-segment scanner with shadowed inputs, LZB, blink and PWM dimming
module seg_scan_n
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 131072,
    parameter int BLINK_FRAMES = 64,
    parameter int BRIGHT_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic [4*N_DIGITS-1:0]   hexs,
    input  logic [N_DIGITS-1:0]     les,
    input  logic [N_DIGITS-1:0]     points,
    input  logic [N_DIGITS-1:0]     blink,
    input  logic                    lzb,
    input  logic [BRIGHT_BITS-1:0]  bright,
    output logic [N_DIGITS-1:0]     AN,
    output logic [7:0]              SEGMENT,
    output logic                    frame_tick
);

    localparam int IW = idx_width(N_DIGITS);
    localparam int SW = (SCAN_DIV <= 2) ? 1 : $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES <= 2) ? 1 : $clog2(BLINK_FRAMES);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [1:0]              rst_sync_q;
    logic                    started_q;
    logic [SW-1:0]           slot_q;
    logic [IW-1:0]           idx_q;
    logic [BW-1:0]           blink_cnt_q;
    logic                    phase_q;
    logic [4*N_DIGITS-1:0]   hexs_q;
    logic [N_DIGITS-1:0]     les_q;
    logic [N_DIGITS-1:0]     points_q;
    logic [N_DIGITS-1:0]     blink_q;
    logic                    lzb_q;
    logic [BRIGHT_BITS-1:0]  bright_q;
    logic [N_DIGITS-1:0]     an_q;
    logic [7:0]              seg_q;
    logic                    frame_tick_q;

    logic                    run;
    logic                    frame_end;
    logic                    capture;
    logic [N_DIGITS-1:0]     lzb_mask;
    logic                    leading;
    logic [3:0]              cur_hex;
    logic                    cur_le;
    logic                    cur_pt;
    logic                    cur_blink;
    logic                    cur_lzb;
    logic [N_DIGITS-1:0]     an_sel;
    logic                    pwm_on;
    logic                    lit;
    logic [6:0]              cur_glyph;
    logic [N_DIGITS-1:0]     an_d;
    logic [7:0]              seg_d;

    assign run       = rst_sync_q[1];
    assign frame_end = started_q && (slot_q == SLOT_LAST) && (idx_q == IDX_LAST);
    // The very first capture after reset release opens frame 0 without a wrap
    assign capture   = run && (!started_q || frame_end);

    seg7_decode u_dec (
        .hex_i (cur_hex),
        .seg_o (cur_glyph)
    );

    always_comb begin
        leading   = 1'b1;
        lzb_mask  = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            leading     = leading && (hexs_q[4*i +: 4] == 4'h0);
            lzb_mask[i] = lzb_q && leading;
        end

        cur_hex   = 4'h0;
        cur_le    = 1'b0;
        cur_pt    = 1'b0;
        cur_blink = 1'b0;
        cur_lzb   = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_hex   = hexs_q[4*i +: 4];
                cur_le    = les_q[i];
                cur_pt    = points_q[i];
                cur_blink = blink_q[i];
                cur_lzb   = lzb_mask[i];
                an_sel[i] = 1'b0;
            end
        end

        pwm_on = (bright_q == '1) || (slot_q[BRIGHT_BITS-1:0] < bright_q);
        lit    = started_q && cur_le && !(cur_blink && !phase_q) && !cur_lzb && pwm_on;
        an_d   = lit ? an_sel : '1;
        seg_d  = lit ? {~cur_pt, cur_glyph} : SEG_OFF;
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rst_sync_q   <= 2'b00;
            started_q    <= 1'b0;
            slot_q       <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b1;
            hexs_q       <= '0;
            les_q        <= '0;
            points_q     <= '0;
            blink_q      <= '0;
            lzb_q        <= 1'b0;
            bright_q     <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            rst_sync_q   <= {rst_sync_q[0], 1'b1};
            frame_tick_q <= capture;
            an_q         <= an_d;
            seg_q        <= seg_d;

            if (capture) begin
                started_q <= 1'b1;
                hexs_q    <= hexs;
                les_q     <= les;
                points_q  <= points;
                blink_q   <= blink;
                lzb_q     <= lzb;
                bright_q  <= bright;
            end

            if (started_q) begin
                if (slot_q == SLOT_LAST) begin
                    slot_q <= '0;
                    if (idx_q == IDX_LAST) begin
                        idx_q <= '0;
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_q <= '0;
                            phase_q     <= ~phase_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + 1'b1;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end else begin
                    slot_q <= slot_q + 1'b1;
                end
            end
        end
    end

    assign AN         = an_q;
    assign SEGMENT    = seg_q;
    assign frame_tick = frame_tick_q;

endmodule
